// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Program counter and fetch controller for a combinational instruction ROM.
//   Sequences one program run: IDLE -> RUN (from StartAddr) -> DONE, with a
//   Done handshake. Start is accepted again from DONE to launch a new run.
//
// Parameters
//   A     instruction address width (ROM depth 2**A)
//   OFFW  width of the signed relative branch offset carried in Target
//
// Ports
//   Clk          rising-edge clock
//   Reset_n      asynchronous active-low reset
//   Start        begin a run at StartAddr (IDLE/DONE only)
//   StartAddr    first instruction address
//   Stall        hold PC and state this cycle
//   Halt         current instruction is a halt
//   BranchEn     take a branch this cycle
//   BranchRel    1: PC + sext(Target[OFFW-1:0]), 0: Target
//   Target       absolute target, or offset in the low OFFW bits
//   Call         with BranchEn: save PC+1 as return address (link build only)
//   Ret          jump to the saved return address (link build only)
//   InstAddress  registered PC, drives the ROM address
//   FetchValid   high while running
//   Done         high once the run has halted
//
// Build option
//   FETCH_LINK_EN  adds a single link register for Call/Ret. When undefined
//                  Call and Ret are accepted but have no effect.
module fetch_sequencer #(
  parameter int A    = 10,
  parameter int OFFW = 6
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [A-1:0] StartAddr,
  input  logic         Stall,
  input  logic         Halt,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic [A-1:0] Target,
  input  logic         Call,
  input  logic         Ret,
  output logic [A-1:0] InstAddress,
  output logic         FetchValid,
  output logic         Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [A-1:0] PC_ONE = A'(1);

  state_t       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [A-1:0] pc_inc;
  logic [A-1:0] rel_target;

  // All PC arithmetic is A bits wide, so wrap-around is implicit.
  assign pc_inc     = pc_q + PC_ONE;
  assign rel_target = pc_q + {{(A-OFFW){Target[OFFW-1]}}, Target[OFFW-1:0]};

`ifdef FETCH_LINK_EN
  logic [A-1:0] link_q, link_d;
`else
  logic unused_link_ports;
  assign unused_link_ports = Call ^ Ret;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
`ifdef FETCH_LINK_EN
      link_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_LINK_EN
      link_q  <= link_d;
`endif
    end
  end

  // Priority inside RUN: Stall > Halt > Ret > BranchEn > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_LINK_EN
    link_d  = link_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = StartAddr;
        end
      end
      S_RUN: begin
        if (!Stall) begin
          if (Halt) begin
            state_d = S_DONE;
          end
`ifdef FETCH_LINK_EN
          else if (Ret) begin
            pc_d = link_q;
          end
`endif
          else if (BranchEn) begin
            pc_d = BranchRel ? rel_target : Target;
`ifdef FETCH_LINK_EN
            if (Call) link_d = pc_inc;
`endif
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign InstAddress = pc_q;
  assign FetchValid  = (state_q == S_RUN);
  assign Done        = (state_q == S_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int A     = 10;
  localparam int OFFW  = 6;
  localparam int DEPTH = 1 << A;

  logic         Clk;
  logic         Reset_n;
  logic         Start;
  logic [A-1:0] StartAddr;
  logic         Stall;
  logic         Halt;
  logic         BranchEn;
  logic         BranchRel;
  logic [A-1:0] Target;
  logic         Call;
  logic         Ret;
  logic [A-1:0] InstAddress;
  logic         FetchValid;
  logic         Done;

  fetch_sequencer #(.A(A), .OFFW(OFFW)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Stall      (Stall),
    .Halt       (Halt),
    .BranchEn   (BranchEn),
    .BranchRel  (BranchRel),
    .Target     (Target),
    .Call       (Call),
    .Ret        (Ret),
    .InstAddress(InstAddress),
    .FetchValid (FetchValid),
    .Done       (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int    pc;
    bit    valid;
    bit    done;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a run flag, a finished flag and an integer PC kept modulo DEPTH.
  int m_pc;
  bit m_running;
  bit m_finished;
  int m_link;

  function automatic void model_reset();
    m_pc = 0; m_running = 0; m_finished = 0; m_link = 0;
  endfunction

  function automatic void model_step();
    int off;
    if (!m_running) begin
      if (Start) begin
        m_running  = 1;
        m_finished = 0;
        m_pc       = int'(StartAddr);
      end
    end else if (!Stall) begin
      if (Halt) begin
        m_running  = 0;
        m_finished = 1;
      end
`ifdef FETCH_LINK_EN
      else if (Ret) begin
        m_pc = m_link;
      end
`endif
      else if (BranchEn) begin
`ifdef FETCH_LINK_EN
        if (Call) m_link = (m_pc + 1) % DEPTH;
`endif
        if (BranchRel) begin
          off = int'(Target[OFFW-1:0]);
          if (off >= (1 << (OFFW-1))) off = off - (1 << OFFW);
          m_pc = (m_pc + off + DEPTH) % DEPTH;
        end else begin
          m_pc = int'(Target);
        end
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endfunction

  function automatic void compare(string tag, int pc, bit v, bit d);
    checks++;
    if (InstAddress !== pc[A-1:0] || FetchValid !== v || Done !== d) begin
      failures++;
      $display("FAIL %s: got pc=%03h valid=%b done=%b, want pc=%03h valid=%b done=%b",
               tag, InstAddress, FetchValid, Done, pc[A-1:0], v, d);
    end
  endfunction

  // Monitor: after every active edge, pop the predicted outputs and compare.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compare(e.tag, e.pc, e.valid, e.done);
    end
  end

  function automatic void push_exp(string tag);
    exp_t e;
    e.pc = m_pc; e.valid = m_running; e.done = m_finished; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  task automatic clear_inputs();
    Start = 0; StartAddr = '0; Stall = 0; Halt = 0; BranchEn = 0;
    BranchRel = 0; Target = '0; Call = 0; Ret = 0;
  endtask

  // Called at a falling edge with inputs already set: predict, queue, advance.
  task automatic cycle(string tag);
    Reset_n = 1'b1;
    model_step();
    push_exp(tag);
    @(negedge Clk);
  endtask

  // Async reset: outputs must clear before any clock edge; held across one edge.
  task automatic do_reset(string tag);
    clear_inputs();
    #2 Reset_n = 1'b0;
    #1 compare({tag, "_async"}, 0, 0, 0);
    model_reset();
    push_exp({tag, "_held"});
    @(negedge Clk);
  endtask

  task automatic set_start(logic [A-1:0] addr);
    clear_inputs(); Start = 1; StartAddr = addr;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    Reset_n = 1'b0;
    #1 compare("reset_state", 0, 0, 0);
    @(negedge Clk);

    // Reset mid-run at PC 0x12.
    set_start(10'h012); cycle("t1_start");
    clear_inputs(); Stall = 1; cycle("t1_stall");
    do_reset("t1_reset");

    // Wrap past the top of the address space.
    set_start(10'h3FD); cycle("t2_start");
    clear_inputs();
    repeat (3) cycle("t2_inc");

    // Relative then absolute branch.
    set_start(10'h040); cycle("t3_start");
    clear_inputs(); BranchEn = 1; BranchRel = 1; Target = 10'h03E; cycle("t3_rel");
    clear_inputs(); BranchEn = 1; BranchRel = 0; Target = 10'h200; cycle("t3_abs");
    clear_inputs(); BranchEn = 1; BranchRel = 1; Target = 10'h21F; cycle("t3_relpos");

    // Stall outranks Halt and branch; then Halt.
    clear_inputs(); Stall = 1; Halt = 1; BranchEn = 1; Target = 10'h155;
    repeat (3) cycle("t4_stall");
    clear_inputs(); Halt = 1; cycle("t4_halt");
    clear_inputs(); cycle("t4_done_hold");

    // Restart from DONE; Start ignored while running.
    set_start(10'h010); cycle("t5_restart");
    set_start(10'h2AA); cycle("t5_start_in_run");
    clear_inputs(); cycle("t5_inc");
    clear_inputs(); Halt = 1; BranchEn = 1; Ret = 1; cycle("t5_halt_over_ret");

    // Call/Ret.
    set_start(10'h020); cycle("t6_start");
    clear_inputs(); BranchEn = 1; Call = 1; Target = 10'h100; cycle("t6_call");
    clear_inputs(); Ret = 1; cycle("t6_ret");
    clear_inputs(); Ret = 1; BranchEn = 1; Target = 10'h0F0; cycle("t6_ret_over_br");
    clear_inputs(); Start = 1; cycle("t6_idle_ignore");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        clear_inputs();
        Start     = ($urandom_range(0, 7) == 0);
        StartAddr = A'($urandom);
        Stall     = ($urandom_range(0, 3) == 0);
        Halt      = ($urandom_range(0, 24) == 0);
        BranchEn  = ($urandom_range(0, 2) == 0);
        BranchRel = $urandom_range(0, 1) == 1;
        Target    = A'($urandom);
        Call      = ($urandom_range(0, 3) == 0);
        Ret       = ($urandom_range(0, 7) == 0);
        cycle("random");
      end
    end

    clear_inputs();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clk);
    if (exp_q.size() > 0) begin
      failures++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
